// File: rtl/hqm_aw_rf_pg_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : hqm_aw_rf_pg_seq_if
// Description : Bundle between the RF power-gate sequencer and its RF/client.
// Revision    : 1.0 - initial release
// ============================================================================
interface hqm_aw_rf_pg_seq_if #(
    parameter int TMO_W = 8
);
    logic             pg_req;
    logic             mem_busy;
    logic [TMO_W-1:0] cfg_ack_timeout;
    logic             err_clr;
    logic             pwr_enable_b;
    logic             pwr_enable_b_ack;
    logic             pgcb_isol_en;
    logic             mem_access_en;
    logic             pg_up;
    logic             pg_down;
    logic             err_timeout;
    logic             err_sticky;

    // Sequencer side
    modport master (
        input  pg_req,
        input  mem_busy,
        input  cfg_ack_timeout,
        input  err_clr,
        input  pwr_enable_b_ack,
        output pwr_enable_b,
        output pgcb_isol_en,
        output mem_access_en,
        output pg_up,
        output pg_down,
        output err_timeout,
        output err_sticky
    );

    // RF wrapper / client / control side
    modport slave (
        output pg_req,
        output mem_busy,
        output cfg_ack_timeout,
        output err_clr,
        output pwr_enable_b_ack,
        input  pwr_enable_b,
        input  pgcb_isol_en,
        input  mem_access_en,
        input  pg_up,
        input  pg_down,
        input  err_timeout,
        input  err_sticky
    );
endinterface
`default_nettype wire

// File: rtl/hqm_aw_rf_pg_seq.sv
`default_nettype none
// ============================================================================
// Module      : hqm_aw_rf_pg_seq
// Description : Power-gate sequencer for a power-gated RF: chain enable,
//               isolation and access gating in glitch-safe order.
// Revision    : 1.0 - initial release
// ============================================================================
module hqm_aw_rf_pg_seq #(
    parameter int ISOL_DLY = 2,
    parameter int TMO_W    = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    hqm_aw_rf_pg_seq_if.master  pg_if
);

    localparam logic [2:0] c_st_off   = 3'd0;
    localparam logic [2:0] c_st_wake  = 3'd1;
    localparam logic [2:0] c_st_uniso = 3'd2;
    localparam logic [2:0] c_st_on    = 3'd3;
    localparam logic [2:0] c_st_drain = 3'd4;
    localparam logic [2:0] c_st_iso   = 3'd5;
    localparam logic [2:0] c_st_sleep = 3'd6;

    localparam logic [3:0]       c_dly_init = 4'(ISOL_DLY - 1);
    localparam logic [TMO_W-1:0] c_tmo_max  = {TMO_W{1'b1}};

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic             r_ack_meta;
    logic             r_ack_s;
    logic [3:0]       r_dly_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_tmo_fired;

    logic             r_pwr_enable_b;
    logic             r_pgcb_isol_en;
    logic             r_mem_access_en;
    logic             r_pg_up;
    logic             r_pg_down;
    logic             r_err_timeout;
    logic             r_err_sticky;

    logic             w_pwr_enable_b_nx;
    logic             w_pgcb_isol_en_nx;
    logic             w_mem_access_en_nx;
    logic             w_pg_up_nx;
    logic             w_pg_down_nx;

    logic             w_state_change;
    logic             w_enter_dly;
    logic             w_enter_wait;
    logic             w_ack_pending;
    logic             w_tmo_hit;

    // ------------------------------------------------------------------
    // State register, synchronizer, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= c_st_off;
            r_ack_meta      <= 1'b1;
            r_ack_s         <= 1'b1;
            r_dly_cnt       <= 4'd0;
            r_tmo_cnt       <= '0;
            r_tmo_fired     <= 1'b0;
            r_pwr_enable_b  <= 1'b1;
            r_pgcb_isol_en  <= 1'b1;
            r_mem_access_en <= 1'b0;
            r_pg_up         <= 1'b0;
            r_pg_down       <= 1'b1;
            r_err_timeout   <= 1'b0;
            r_err_sticky    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_ack_meta <= pg_if.pwr_enable_b_ack;
            r_ack_s    <= r_ack_meta;

            if (w_enter_dly) begin
                r_dly_cnt <= c_dly_init;
            end else if (r_dly_cnt != 4'd0) begin
                r_dly_cnt <= r_dly_cnt - 4'd1;
            end

            if (w_enter_wait) begin
                r_tmo_cnt   <= '0;
                r_tmo_fired <= 1'b0;
            end else begin
                if ((r_state == c_st_wake || r_state == c_st_sleep) && r_tmo_cnt != c_tmo_max) begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
                if (w_tmo_hit) begin
                    r_tmo_fired <= 1'b1;
                end
            end

            r_pwr_enable_b  <= w_pwr_enable_b_nx;
            r_pgcb_isol_en  <= w_pgcb_isol_en_nx;
            r_mem_access_en <= w_mem_access_en_nx;
            r_pg_up         <= w_pg_up_nx;
            r_pg_down       <= w_pg_down_nx;
            r_err_timeout   <= w_tmo_hit;

            // A new timeout outranks a simultaneous clear
            if (w_tmo_hit) begin
                r_err_sticky <= 1'b1;
            end else if (pg_if.err_clr) begin
                r_err_sticky <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_off:   if (!pg_if.pg_req)     w_next_state = c_st_wake;
            c_st_wake:  if (!r_ack_s)          w_next_state = c_st_uniso;
            c_st_uniso: if (r_dly_cnt == 4'd0) w_next_state = c_st_on;
            c_st_on:    if (pg_if.pg_req)      w_next_state = c_st_drain;
            c_st_drain: if (!pg_if.mem_busy)   w_next_state = c_st_iso;
            c_st_iso:   if (r_dly_cnt == 4'd0) w_next_state = c_st_sleep;
            c_st_sleep: if (r_ack_s)           w_next_state = c_st_off;
            default:                           w_next_state = c_st_off;
        endcase
    end

    // Entry detection and ack-timeout qualification
    always_comb begin
        w_state_change = (w_next_state != r_state);
        w_enter_dly    = w_state_change &&
                         (w_next_state == c_st_uniso || w_next_state == c_st_iso);
        w_enter_wait   = w_state_change &&
                         (w_next_state == c_st_wake || w_next_state == c_st_sleep);
        // Ack already at target this cycle suppresses the error
        w_ack_pending  = ((r_state == c_st_wake)  &&  r_ack_s) ||
                         ((r_state == c_st_sleep) && !r_ack_s);
        w_tmo_hit      = w_ack_pending && !r_tmo_fired &&
                         (pg_if.cfg_ack_timeout != '0) &&
                         (r_tmo_cnt == pg_if.cfg_ack_timeout);
    end

    // ------------------------------------------------------------------
    // Output decode of the upcoming state, registered above
    // ------------------------------------------------------------------
    always_comb begin
        w_pwr_enable_b_nx  = 1'b0;
        w_pgcb_isol_en_nx  = 1'b1;
        w_mem_access_en_nx = 1'b0;
        w_pg_up_nx         = 1'b0;
        w_pg_down_nx       = 1'b0;
        case (w_next_state)
            c_st_off: begin
                w_pwr_enable_b_nx = 1'b1;
                w_pg_down_nx      = 1'b1;
            end
            c_st_wake, c_st_uniso, c_st_iso: begin
                w_pwr_enable_b_nx = 1'b0;
            end
            c_st_on: begin
                w_pgcb_isol_en_nx  = 1'b0;
                w_mem_access_en_nx = 1'b1;
                w_pg_up_nx         = 1'b1;
            end
            c_st_drain: begin
                w_pgcb_isol_en_nx = 1'b0;
            end
            c_st_sleep: begin
                w_pwr_enable_b_nx = 1'b1;
            end
            default: begin
                w_pwr_enable_b_nx = 1'b1;
                w_pg_down_nx      = 1'b1;
            end
        endcase
    end

    assign pg_if.pwr_enable_b  = r_pwr_enable_b;
    assign pg_if.pgcb_isol_en  = r_pgcb_isol_en;
    assign pg_if.mem_access_en = r_mem_access_en;
    assign pg_if.pg_up         = r_pg_up;
    assign pg_if.pg_down       = r_pg_down;
    assign pg_if.err_timeout   = r_err_timeout;
    assign pg_if.err_sticky    = r_err_sticky;

endmodule
`default_nettype wire
